mdu_sched: RTL

- Multiply/divide scheduler for the 5-stage MIPS pipeline, sitting beside the EX stage.
- Accepts mult/multu/div/divu/mthi/mtlo issued from the E-stage pipeline register and owns the HI/LO registers.
- Models the multi-cycle execution latency.
- Generates the stall/bubble control that freezes the F/D registers and clears the E-stage register while a D-stage HI/LO-using instruction must wait.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_if.sv | 30 +++
 rtl/mdu_arith.sv | 57 +++++
 rtl/mdu_sched.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide scheduler.
//   mdu_op_e    - MDU operation code carried on E_Op
//   mdu_state_e - scheduler FSM state
//   CNT_W       - width of the latency down-counter
//   is_muldiv() - true for the multi-cycle operations that occupy the unit
package mdu_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  localparam int CNT_W = 4;

  function automatic logic is_muldiv(input mdu_op_e op);
    logic res;
    case (op)
      MULT, MULTU, DIV, DIVU: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: E/D-stage side of the multiply/divide scheduler.
//   E_Start/E_Op/E_A/E_B - MDU instruction issued from the E-stage register
//   D_IsMD               - D-stage instruction uses the MDU or HI/LO
//   Busy/HI/LO           - scheduler status and architectural HI/LO
//   Stall_D              - freeze F/D, bubble E
// master = pipeline side, slave = scheduler side.
interface mdu_if;
  import mdu_pkg::*;

  logic        E_Start;
  mdu_op_e     E_Op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_IsMD;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Stall_D;

  modport master (
    output E_Start, E_Op, E_A, E_B, D_IsMD,
    input  Busy, HI, LO, Stall_D
  );

  modport slave (
    input  E_Start, E_Op, E_A, E_B, D_IsMD,
    output Busy, HI, LO, Stall_D
  );

endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit multiply / divide datapath.
//   op       - operation code
//   a, b     - rs / rt operands
//   result   - {HI, LO}: {upper, lower} product or {remainder, quotient}
//   div_zero - division requested with a zero divisor
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] a_sx_s;
  logic [63:0] b_sx_s;
  logic [31:0] b_safe_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] q_sgn_s;
  logic [31:0] r_sgn_s;

  // Operand conditioning and result selection.
  always_comb begin
    a_sx_s   = {{32{a[31]}}, a};
    b_sx_s   = {{32{b[31]}}, b};
    // A zero divisor is replaced by 1 so the divider never sees 0;
    // the div_zero flag stops the bogus result reaching HI/LO.
    b_safe_s = (b == 32'd0) ? 32'd1 : b;
    // Signed division via magnitudes avoids the -2^31 / -1 corner
    // of native signed division and gives truncation toward zero.
    a_mag_s  = a[31] ? (~a + 32'd1) : a;
    b_mag_s  = b[31] ? (~b + 32'd1) : b_safe_s;
    q_mag_s  = a_mag_s / b_mag_s;
    r_mag_s  = a_mag_s % b_mag_s;
    q_sgn_s  = (a[31] ^ b[31]) ? (~q_mag_s + 32'd1) : q_mag_s;
    r_sgn_s  = a[31] ? (~r_mag_s + 32'd1) : r_mag_s;

    case (op)
      MULT:    result = a_sx_s * b_sx_s;
      MULTU:   result = {32'd0, a} * {32'd0, b};
      DIV:     result = {r_sgn_s, q_sgn_s};
      DIVU:    result = {a % b_safe_s, a / b_safe_s};
      default: result = 64'd0;
    endcase

    if ((op == DIV) || (op == DIVU)) begin
      div_zero = (b == 32'd0);
    end else begin
      div_zero = 1'b0;
    end
  end

endmodule

// File: rtl/mdu_sched.sv
// mdu_sched: multiply/divide scheduler beside the EX stage.
//   Clk, Rst - clock (rising edge), synchronous active-high reset
//   bus      - mdu_if.slave: issue from E, D-stage MD flag, Busy/HI/LO/Stall_D
// A mult/div issued in cycle c latches its result at the end of c, keeps
// Busy high for cycles c+1..c+LAT and commits HI/LO at the edge ending c+LAT.
module mdu_sched
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic Clk,
  input  logic Rst,
  mdu_if.slave bus
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

  mdu_state_e       state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [63:0]      pend_r, pend_n;
  logic             pend_dz_r, pend_dz_n;
  logic [31:0]      hi_r, hi_n;
  logic [31:0]      lo_r, lo_n;
  logic             busy_r, busy_n;

  logic             is_md_s;
  logic             is_mul_s;
  logic [63:0]      arith_res_s;
  logic             arith_dz_s;

  assign is_md_s  = bus.E_Start & is_muldiv(bus.E_Op);
  assign is_mul_s = (bus.E_Op == MULT) || (bus.E_Op == MULTU);

  mdu_arith u_arith (
    .op       (bus.E_Op),
    .a        (bus.E_A),
    .b        (bus.E_B),
    .result   (arith_res_s),
    .div_zero (arith_dz_s)
  );

  // Next-state, counter, pending result and HI/LO update.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    pend_n    = pend_r;
    pend_dz_n = pend_dz_r;
    hi_n      = hi_r;
    lo_n      = lo_r;

    case (state_r)
      IDLE: begin
        if (is_md_s) begin
          state_n   = BUSY;
          cnt_n     = is_mul_s ? MUL_CNT : DIV_CNT;
          pend_n    = arith_res_s;
          pend_dz_n = arith_dz_s;
        end else if (bus.E_Start && (bus.E_Op == MTHI)) begin
          hi_n = bus.E_A;
        end else if (bus.E_Start && (bus.E_Op == MTLO)) begin
          lo_n = bus.E_A;
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        // Any E_Start seen here is ignored: the stall keeps it from happening.
        if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_n = IDLE;
          cnt_n   = {CNT_W{1'b0}};
          if (!pend_dz_r) begin
            hi_n = pend_r[63:32];
            lo_n = pend_r[31:0];
          end else begin
            hi_n = hi_r;
            lo_n = lo_r;
          end
        end else begin
          cnt_n = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = {CNT_W{1'b0}};
      end
    endcase

    busy_n = (state_n == BUSY);
  end

  // State, counter, pending result and architectural HI/LO registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      pend_r    <= 64'd0;
      pend_dz_r <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      pend_r    <= pend_n;
      pend_dz_r <= pend_dz_n;
      hi_r      <= hi_n;
      lo_r      <= lo_n;
      busy_r    <= busy_n;
    end
  end

  // The stall also covers the issue cycle, so a HI/LO consumer in D
  // waits until the cycle after completion and then forwards the new value.
  assign bus.Stall_D = bus.D_IsMD & (busy_r | is_md_s);
  assign bus.Busy    = busy_r;
  assign bus.HI      = hi_r;
  assign bus.LO      = lo_r;

endmodule
